base3_to_base2: RTL and testbench

Serial ternary-to-binary converter, the inverse of the base-2 → base-3 conversion path, which produces ternary digits by repeated division by 3. The block accepts a stream of ternary digits, most significant first, over a valid/ready handshake. It accumulates them by Horner's rule, value = value·3 + digit, and presents the binary result plus status flags on a valid/ready output port.

---
 rtl/base3_to_base2.sv | 127 ++++++++++++
 tb/tb_base3_to_base2.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/base3_to_base2.sv
// Purpose : serial ternary-to-binary converter, MSD first, Horner accumulation (acc*3 + d).
// Latency : result valid right after the edge that accepts the last digit; one bubble between numbers.
// Backpressure: holds the result while out_ready=0; in_ready is low for the whole DONE phase.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   digit handshake; in_digit (0..2) and in_last qualify the digit
//   out_valid/out_ready result handshake
//   out_value           binary result modulo 2^WIDTH
//   out_count           accepted digits, saturating at 2^CW-1
//   overflow            sticky: the exact value exceeded 2^WIDTH-1 at some step
//   err                 sticky: illegal digit 3 seen (only with B3B2_DIGIT_CHECK_EN, else 0)
//
// Optional build macro: B3B2_DIGIT_CHECK_EN enables illegal-digit detection.
module base3_to_base2 #(
  parameter int WIDTH = 16,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_digit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [CW-1:0]    out_count,
  output logic             overflow,
  output logic             err
);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [1:0]         digit_eff;
  logic [WIDTH+1:0]   sum_w;
  logic               accept;

  assign accept = in_valid && (state_q == ACC);

`ifdef B3B2_DIGIT_CHECK_EN
  logic err_q, err_d;
  // A digit of 3 is flagged and contributes nothing to the value.
  assign digit_eff = (in_digit == 2'd3) ? 2'd0 : in_digit;
`else
  // Raw 2-bit value is accumulated unchecked.
  assign digit_eff = in_digit;
`endif

  // acc*3 + d in two extra bits so any carry out of WIDTH is visible.
  assign sum_w = ({2'b00, acc_q} << 1) + {2'b00, acc_q} + {{WIDTH{1'b0}}, digit_eff};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
`ifdef B3B2_DIGIT_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      ACC: begin
        if (accept) begin
          acc_d = sum_w[WIDTH-1:0];
          if (sum_w[WIDTH+1:WIDTH] != 2'b00) ovf_d = 1'b1;
          if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
`ifdef B3B2_DIGIT_CHECK_EN
          if (in_digit == 2'd3) err_d = 1'b1;
`endif
          if (in_last) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
`ifdef B3B2_DIGIT_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef B3B2_DIGIT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Handshake outputs decode straight from the state flop, so nothing
  // combinational from inputs reaches an output.
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign out_value = acc_q;
  assign out_count = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_base3_to_base2.sv
module tb_base3_to_base2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_digit = 2'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_value;
  logic [4:0]  out_count;
  logic        overflow;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] dq[$];

  base3_to_base2 #(.WIDTH(16), .CW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_count(out_count),
    .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive the digits in dq, last flag on the final one; returns #1 after the final edge.
  task automatic send_num();
    for (int i = 0; i < dq.size(); i++) begin
      chk("in_ready_acc", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_digit = dq[i];
      in_last  = (i == dq.size() - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_digit = 2'd0;
  endtask

  task automatic check_result(input string tag, input logic [15:0] v, input logic [4:0] c,
                              input logic o, input logic e);
    chk({tag, "_vld"},   {31'd0, out_valid}, 32'd1);
    chk({tag, "_rdy"},   {31'd0, in_ready},  32'd0);
    chk({tag, "_value"}, {16'd0, out_value}, {16'd0, v});
    chk({tag, "_count"}, {27'd0, out_count}, {27'd0, c});
    chk({tag, "_ovf"},   {31'd0, overflow},  {31'd0, o});
    chk({tag, "_err"},   {31'd0, err},       {31'd0, e});
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_turn_rdy"}, {31'd0, in_ready},  32'd1);
    chk({tag, "_turn_vld"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_clr_val"},  {16'd0, out_value}, 32'd0);
    chk({tag, "_clr_cnt"},  {27'd0, out_count}, 32'd0);
    chk({tag, "_clr_ovf"},  {31'd0, overflow},  32'd0);
  endtask

  initial begin
    // Reset state while rst_n is held low.
    #2;
    chk("rst_rdy",   {31'd0, in_ready},  32'd1);
    chk("rst_vld",   {31'd0, out_valid}, 32'd0);
    chk("rst_value", {16'd0, out_value}, 32'd0);
    chk("rst_count", {27'd0, out_count}, 32'd0);
    chk("rst_ovf",   {31'd0, overflow},  32'd0);
    chk("rst_err",   {31'd0, err},       32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1,2,1 -> 16; valid right after the edge taking the last digit.
    dq = '{2'd1, 2'd2, 2'd1};
    send_num();
    check_result("n121", 16'd16, 5'd3, 1'b0, 1'b0);
    consume("n121");

    // Largest value without overflow.
    dq = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd0};
    send_num();
    check_result("max", 16'd65535, 5'd11, 1'b0, 1'b0);
    consume("max");

    // Eleven 2s: 177146 mod 65536 = 46074, overflow set.
    dq = '{};
    for (int i = 0; i < 11; i++) dq.push_back(2'd2);
    send_num();
    check_result("ovf", 16'd46074, 5'd11, 1'b1, 1'b0);
    consume("ovf");

    // Illegal digit in the middle.
    dq = '{2'd1, 2'd3, 2'd1};
    send_num();
`ifdef B3B2_DIGIT_CHECK_EN
    check_result("ill", 16'd10, 5'd3, 1'b0, 1'b1);
`else
    check_result("ill", 16'd19, 5'd3, 1'b0, 1'b0);
`endif
    consume("ill");
    chk("ill_clr_err", {31'd0, err}, 32'd0);

    // 33 leading zeros then a 1: count saturates at 31, value 1.
    dq = '{};
    for (int i = 0; i < 33; i++) dq.push_back(2'd0);
    dq.push_back(2'd1);
    send_num();
    check_result("sat", 16'd1, 5'd31, 1'b0, 1'b0);
    consume("sat");

    // Backpressure: hold result 5 cycles, stray input during DONE must be ignored.
    dq = '{2'd2};
    send_num();
    in_valid = 1'b1;
    in_digit = 2'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_result("hold", 16'd2, 5'd1, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    in_digit = 2'd0;
    consume("hold");
    dq = '{2'd1};
    send_num();
    check_result("after", 16'd1, 5'd1, 1'b0, 1'b0);
    consume("after");

    // Reset mid-number discards the partial value.
    in_valid = 1'b1;
    in_digit = 2'd2;
    in_last  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_partial", {16'd0, out_value}, 32'd8);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy",   {31'd0, in_ready},  32'd1);
    chk("mid_rst_vld",   {31'd0, out_valid}, 32'd0);
    chk("mid_rst_value", {16'd0, out_value}, 32'd0);
    chk("mid_rst_count", {27'd0, out_count}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dq = '{2'd1};
    send_num();
    check_result("post_rst", 16'd1, 5'd1, 1'b0, 1'b0);
    consume("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
